// File: rtl/cla_serial_adder.sv
// cla_serial_adder: multi-cycle WIDTH-bit adder that feeds one operand nibble
// per clock (LSB first) through a 4-bit carry-lookahead slice, registering the
// inter-nibble carry. Operands arrive on a valid/ready handshake and the result
// leaves on another.
// Optional feature: define CLA_SERIAL_OVF_EN to add the signed-overflow output ovf.
module cla_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             cout_reg;
    logic             ovf_reg;

    logic [3:0] na;
    logic [3:0] nb;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] s;
    logic [4:0] c;
    logic       last;

    // CLA nibble slice on the current nibble, plus the sum with that nibble merged in
    always_comb begin
        na = 4'(a_reg >> {idx, 2'b00});
        nb = 4'(b_reg >> {idx, 2'b00});
        p  = na ^ nb;
        g  = na & nb;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
        last = (idx == IW'(NIB - 1));
        sum_next = sum_reg;
        for (int k = 0; k < NIB; k++) begin
            if (idx == IW'(k)) begin
                sum_next[4*k +: 4] = s;
            end
        end
    end

    // Handshake FSM, operand capture and nibble-by-nibble accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= cin;
                        idx     <= '0;
                        sum_reg <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_reg <= sum_next;
                    carry   <= c[4];
                    if (last) begin
                        cout_reg <= c[4];
                        // carry into the MSB vs carry out of it
                        ovf_reg  <= c[4] ^ c[3];
                        idx      <= '0;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

`ifdef CLA_SERIAL_OVF_EN
    assign ovf = ovf_reg;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder (WIDTH=16): table of operand vectors with
// hand-computed results plus sequences for backpressure, mid-op reset and
// back-to-back streaming. Define CLA_SERIAL_OVF_EN to also check ovf.
module tb_cla_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic        ovf;

    int n_cmp;
    int n_bad;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] es;
        logic        eco;
        logic        eov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Accept one op from IDLE, wait for the result, check it, then release it.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         input logic [15:0] es, input logic eco, input logic eov,
                         input bit disturb);
        int cyc;
        check("in_ready before op", {31'b0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tcin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (disturb) begin
            a = 16'hAAAA; b = 16'h5555; cin = ~tcin;
        end
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 32'd4);
        check("sum", {16'b0, sum}, {16'b0, es});
        check("cout", {31'b0, cout}, {31'b0, eco});
`ifdef CLA_SERIAL_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, eov});
`else
        if (eov === 1'bx) $display("note: bad vector");
`endif
        check("in_ready in DONE", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid after release", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nres;
        int t1;
        int t2;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[9] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset sum", {16'b0, sum}, 32'd0);
        check("reset cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", {31'b0, in_ready}, 32'd1);

        // Table vectors; vector 1 also scribbles on the inputs during RUN
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].es, vecs[i].eco,
                  vecs[i].eov, (i == 1));
        end

        // Backpressure: result held for 3 cycles, stray in_valid ignored
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp latency", cyc, 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("bp out_valid", {31'b0, out_valid}, 32'd1);
            check("bp sum", {16'b0, sum}, 32'd0);
            check("bp cout", {31'b0, cout}, 32'd1);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
            if (i == 1) in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("bp out_valid held", {31'b0, out_valid}, 32'd1);
        check("bp sum held", {16'b0, sum}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp released", {31'b0, out_valid}, 32'd0);
        check("bp no stray accept", {31'b0, busy}, 32'd0);

        // Reset in the middle of RUN (idx=2), cout still 1 from previous op
        a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("partial sum in RUN", {16'b0, sum}, 32'h0022);
        check("busy in RUN", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst sum", {16'b0, sum}, 32'd0);
        check("async rst cout", {31'b0, cout}, 32'd0);
        check("async rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after mid reset", {31'b0, in_ready}, 32'd1);
        check("no result after mid reset", {31'b0, out_valid}, 32'd0);
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        nres = 0; t1 = 0; t2 = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            end
            if (out_valid) begin
                nres++;
                if (nres == 1) begin
                    t1 = e;
                    check("b2b sum1", {16'b0, sum}, 32'h0100);
                    check("b2b cout1", {31'b0, cout}, 32'd0);
                end else begin
                    t2 = e;
                    check("b2b sum2", {16'b0, sum}, 32'hFFFF);
                    check("b2b cout2", {31'b0, cout}, 32'd1);
                end
            end
            if (nres == 1 && busy && !out_valid) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b result count", nres, 32'd2);
        check("b2b spacing", t2 - t1, 32'd6);
        check("b2b idle at end", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
